// File: rtl/cache_victim_fill_pkg.sv
// ============================================================================
// Package : cache_victim_fill_pkg
// Brief   : Shared types and default line geometry for the miss/victim engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cache_victim_fill_pkg;

  localparam int c_LINELEN = 512;
  localparam int c_BUSW    = 64;
  localparam int c_BEATS   = c_LINELEN / c_BUSW;
  localparam int c_BEATW   = $clog2(c_BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RDVICTIM = 3'd1,
    CAPTURE  = 3'd2,
    WRBACK   = 3'd3,
    FETCH    = 3'd4,
    INSTALL  = 3'd5,
    DONE     = 3'd6
  } victimfill_state_t;

endpackage

`default_nettype wire

// File: rtl/cachelinebuf.sv
// ============================================================================
// Module : cachelinebuf
// Brief  : Line buffer with whole-line load, per-beat write and beat read mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cachelinebuf #(
  parameter int LINELEN = 512,
  parameter int BUSW    = 64
) (
  input  logic                               clk,
  input  logic                               load,
  input  logic [LINELEN-1:0]                 linein,
  input  logic                               wen,
  input  logic [$clog2(LINELEN/BUSW)-1:0]    idx,
  input  logic [BUSW-1:0]                    wdata,
  output logic [LINELEN-1:0]                 line,
  output logic [BUSW-1:0]                    rdata
);

  localparam int c_BEATS = LINELEN / BUSW;

  logic [c_BEATS-1:0][BUSW-1:0] r_buf;

  // Slice k occupies bits [k*BUSW +: BUSW], so beat order equals address order.
  always_ff @(posedge clk) begin
    if (load)     r_buf      <= linein;
    else if (wen) r_buf[idx] <= wdata;
  end

  assign line  = r_buf;
  assign rdata = r_buf[idx];

endmodule

`default_nettype wire

// File: rtl/flopenr.sv
// ============================================================================
// Module : flopenr
// Brief  : Enabled register with synchronous active-high reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/cache_victim_fill.sv
// ============================================================================
// Module : cache_victim_fill
// Brief  : Victim writeback and line fill engine between cache FSM and bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_victim_fill
  import cache_victim_fill_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9,
  parameter int TAGLEN  = 20,
  parameter int LINELEN = 512,
  parameter int BUSW    = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             MissReq,
  input  logic [SETLEN-1:0]                MissSet,
  input  logic [TAGLEN-1:0]                MissTag,
  input  logic [NUMWAYS-1:0]               VictimWay,
  input  logic                             VictimValid,
  input  logic                             VictimDirty,
  input  logic [TAGLEN-1:0]                VictimTag,
  output logic                             Busy,
  output logic                             MissDone,
  output logic                             ArrayRdEn,
  input  logic [LINELEN-1:0]               LineRdData,
  output logic                             ArrayWrEn,
  output logic [NUMWAYS-1:0]               ArrayWay,
  output logic [SETLEN-1:0]                ArraySet,
  output logic [TAGLEN-1:0]                ArrayWrTag,
  output logic [LINELEN-1:0]               ArrayWrData,
  output logic                             BusReq,
  output logic                             BusWrite,
  output logic [TAGLEN+SETLEN-1:0]         BusAdr,
  output logic [$clog2(LINELEN/BUSW)-1:0]  BusBeat,
  output logic [BUSW-1:0]                  BusWData,
  input  logic                             BusBeatAck,
  input  logic [BUSW-1:0]                  BusRData
);

  localparam int c_BEATS = LINELEN / BUSW;
  localparam int c_BEATW = $clog2(c_BEATS);

  victimfill_state_t    r_state;
  logic [TAGLEN-1:0]    r_vtag;
  logic                 w_start;
  logic                 w_bus_phase;
  logic                 w_beat_en;
  logic                 w_lastbeat;
  logic [c_BEATW-1:0]   w_beat_nxt;

  assign w_start     = (r_state == IDLE) && MissReq;
  assign w_bus_phase = (r_state == WRBACK) || (r_state == FETCH);
  assign w_beat_en   = w_bus_phase && BusBeatAck;
  assign w_lastbeat  = (BusBeat == c_BEATW'(c_BEATS - 1));
  // Power-of-two beat count lets the counter wrap to 0 on its own.
  assign w_beat_nxt  = BusBeat + c_BEATW'(1);

  // Latched request fields hold their value; they are never reset.
  flopenr #(.WIDTH(SETLEN))  u_set  (.clk(clk), .reset(1'b0), .en(w_start), .d(MissSet),   .q(ArraySet));
  flopenr #(.WIDTH(TAGLEN))  u_mtag (.clk(clk), .reset(1'b0), .en(w_start), .d(MissTag),   .q(ArrayWrTag));
  flopenr #(.WIDTH(NUMWAYS)) u_way  (.clk(clk), .reset(1'b0), .en(w_start), .d(VictimWay), .q(ArrayWay));
  flopenr #(.WIDTH(TAGLEN))  u_vtag (.clk(clk), .reset(1'b0), .en(w_start), .d(VictimTag), .q(r_vtag));

  flopenr #(.WIDTH(c_BEATW)) u_beat (
    .clk(clk), .reset(reset), .en(w_beat_en), .d(w_beat_nxt), .q(BusBeat)
  );

  cachelinebuf #(.LINELEN(LINELEN), .BUSW(BUSW)) u_linebuf (
    .clk    (clk),
    .load   (r_state == CAPTURE),
    .linein (LineRdData),
    .wen    (w_beat_en && (r_state == FETCH)),
    .idx    (BusBeat),
    .wdata  (BusRData),
    .line   (ArrayWrData),
    .rdata  (BusWData)
  );

  assign BusAdr = {(r_state == WRBACK) ? r_vtag : ArrayWrTag, ArraySet};

  // Outputs are set together with the state they belong to, so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      Busy      <= 1'b0;
      MissDone  <= 1'b0;
      ArrayRdEn <= 1'b0;
      ArrayWrEn <= 1'b0;
      BusReq    <= 1'b0;
      BusWrite  <= 1'b0;
    end else begin
      MissDone  <= 1'b0;
      ArrayRdEn <= 1'b0;
      ArrayWrEn <= 1'b0;
      case (r_state)
        IDLE: begin
          if (MissReq) begin
            Busy <= 1'b1;
            if (VictimValid && VictimDirty) begin
              r_state   <= RDVICTIM;
              ArrayRdEn <= 1'b1;
            end else begin
              r_state  <= FETCH;
              BusReq   <= 1'b1;
              BusWrite <= 1'b0;
            end
          end
        end
        RDVICTIM: r_state <= CAPTURE;
        CAPTURE: begin
          r_state  <= WRBACK;
          BusReq   <= 1'b1;
          BusWrite <= 1'b1;
        end
        WRBACK: begin
          if (BusBeatAck && w_lastbeat) begin
            r_state  <= FETCH;
            BusWrite <= 1'b0;
          end
        end
        FETCH: begin
          if (BusBeatAck && w_lastbeat) begin
            r_state   <= INSTALL;
            BusReq    <= 1'b0;
            ArrayWrEn <= 1'b1;
          end
        end
        INSTALL: begin
          r_state  <= DONE;
          MissDone <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          Busy    <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          Busy     <= 1'b0;
          BusReq   <= 1'b0;
          BusWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
